ahb_sub_mem: RTL
================

Name: ahb_sub_mem

Overview:
- AHB-Lite subordinate (responder) memory model; the opposite end of the VProc AHB manager BFM.
- Decodes and accepts manager transfers, applies a configurable number of wait states, and services reads and writes from an internal word array.
- Gives two-cycle ERROR responses for illegal accesses.
- Used as the default target in AHB BFM testbenches.

Parameters:
- ADDRWIDTH, 32, address width (32 or 64)
- DATAWIDTH, ADDRWIDTH, data width (32 or 64)
- MEM_WORDS, 1024, array depth in DATAWIDTH words (power of two)
- BASE_ADDR, 0, byte address of word 0 (aligned to MEM_WORDS*DATAWIDTH/8)
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer (0..15)

Ports:
- hclk  in  1  clock; all state changes on the rising edge
- hreset  in  1  synchronous, active-high reset
- hsel  in  1  subordinate select
- haddr  in  ADDRWIDTH  byte address (address phase)
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write (address phase)
- hsize  in  3  transfer size (address phase)
- hburst  in  3  burst type; ignored apart from protocol legality
- hwstrb  in  DATAWIDTH/8  byte strobes, sampled with the address phase
- hwdata  in  DATAWIDTH  write data (data phase)
- hready  in  1  bus-level ready; address phase is taken only when high
- hreadyout  out  1  subordinate ready
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  DATAWIDTH  read data, valid when hreadyout=1 in a read data phase

Behaviour:
- One clock (hclk). Reset is synchronous and active-high (hreset).
- Reset values:
  - hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0.
  - Any pending write is discarded.
  - Memory contents are not reset.
- Accept condition: hsel & hready & htrans[1] at a rising edge. The latch holds haddr word index, hwrite, hwstrb and an error flag.
- Error flag is set when any of these hold:
  - address outside BASE_ADDR .. BASE_ADDR+MEM_WORDS*DATAWIDTH/8-1;
  - hsize > log2(DATAWIDTH/8);
  - haddr not aligned to 2^hsize.
- IDLE/BUSY, or hsel=0 with hready=1: no state change. Next cycle is hreadyout=1, hresp=0.
- FSM states:
  - IDLE: no data phase outstanding. hreadyout=1, hresp=0.
    - Accept with error → ERR1.
    - Accept OKAY with WAIT_STATES=0 → DATA.
    - Accept OKAY with WAIT_STATES>0 → WAIT, counter=WAIT_STATES-1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 → DATA.
  - DATA: hreadyout=1, hresp=0; final data-phase cycle.
    - Write: at the edge, mem[idx] is updated per byte lane where hwstrb bit=1, from hwdata.
    - A new accept in the same cycle follows the IDLE transition rules; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=1. No memory access. Address phase presented in this cycle is ignored. → ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept follows the IDLE rules, else → IDLE.
- Latency: an OKAY data phase lasts WAIT_STATES+1 cycles. An ERROR data phase is always 2 cycles.
- Read data:
  - hrdata is registered on the accept edge as mem[idx]. Memory cannot change during that read's data phase.
  - Full word is returned regardless of hsize; the manager selects lanes.
  - Forwarding: if a write in DATA commits on the same edge a read to the same idx is accepted, hrdata takes the new data on strobed lanes and the old memory on the others.
- Non-read data phases: hrdata holds its previous value.
- Writes to error addresses never modify memory.
- Reset asserted mid-WAIT or mid-ERR1: next cycle is IDLE. The interrupted write is not committed.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 (hwstrb=0xF), immediately followed by a NONSEQ read of 0x10 → both data phases 1 cycle; read hrdata=0xDEADBEEF (forwarded), hresp=0.
- WAIT_STATES=2: single read of 0x20 preloaded with 0x12345678 → hreadyout low exactly 2 cycles, then high with hrdata=0x12345678.
- Byte strobes: word 0x30=0x00000000; write 0xAABBCCDD with hwstrb=0x5; read 0x30 → 0x00BB00DD.
- 4-beat INCR write burst to 0x40..0x4C (SEQ beats), WAIT_STATES=1, then read back → each beat is 2 cycles; data matches; hburst is ignored.
- Out of range: read at BASE_ADDR+MEM_WORDS*4 → hreadyout/hresp = 0/1 then 1/1. A NONSEQ presented during ERR1 is ignored; one presented during ERR2 is accepted.
- Misaligned halfword write (hsize=1, haddr=0x41) → two-cycle ERROR; word 0x40 unchanged. Also hreset asserted during WAIT of a write → hreadyout=1 next cycle; memory unchanged.

Source files
------------

// File: rtl/ahb_sub_mem.sv
`timescale 1ns/1ps
// ahb_sub_mem
// AHB-Lite subordinate memory model. It accepts manager transfers and
// inserts WAIT_STATES wait cycles on each OKAY transfer. Reads and writes
// are served from an internal word array. Illegal accesses get a
// two-cycle ERROR response.
//
// Ports:
//   hclk, hreset        clock; synchronous active-high reset
//   hsel, hready        subordinate select and bus-level ready
//   haddr, htrans       address-phase byte address and transfer type
//   hwrite, hsize       address-phase direction and size
//   hburst              burst type (only consumed, never acted on)
//   hwstrb              byte strobes, captured with the address phase
//   hwdata              write data, taken in the final data-phase cycle
//   hreadyout, hresp    subordinate ready and response (0=OKAY, 1=ERROR)
//   hrdata              read data, registered when the read is accepted
//   fsm_state           current FSM state for observation
//                       (0=IDLE, 1=WAIT, 2=DATA, 3=ERR1, 4=ERR2)
//
// Handshake: a transfer is taken on a rising edge where
// hsel & hready & htrans[1] holds and the FSM can start a new data phase
// (IDLE, DATA or ERR2). A data phase ends on the first edge with hreadyout=1.
module ahb_sub_mem #(
    parameter int                   ADDRWIDTH   = 32,
    parameter int                   DATAWIDTH   = ADDRWIDTH,
    parameter int                   MEM_WORDS   = 1024,
    parameter logic [ADDRWIDTH-1:0] BASE_ADDR   = '0,
    parameter int                   WAIT_STATES = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   hsel,
    input  logic [ADDRWIDTH-1:0]   haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [DATAWIDTH/8-1:0] hwstrb,
    input  logic [DATAWIDTH-1:0]   hwdata,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [DATAWIDTH-1:0]   hrdata,
    output logic [2:0]             fsm_state
);

    localparam int         BYTES     = DATAWIDTH / 8;
    localparam int         OFF_W     = $clog2(BYTES);
    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam int         HI_LSB    = OFF_W + IDX_W;
    localparam logic [2:0] SIZE_MAX  = 3'(OFF_W);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           wcnt, wcnt_nxt;
    logic [IDX_W-1:0]     lat_idx;
    logic                 lat_write;
    logic [BYTES-1:0]     lat_strb;
    logic [DATAWIDTH-1:0] mem [MEM_WORDS];

    logic                 accept, can_accept, take, commit;
    logic                 addr_err, misalign;
    logic [IDX_W-1:0]     idx;
    logic [DATAWIDTH-1:0] rd_word;
    logic                 unused_ok;

    // hburst and htrans[0] have no effect on how a transfer is serviced.
    assign unused_ok = &{1'b0, hburst, htrans[0]};

    assign idx        = haddr[HI_LSB-1:OFF_W];
    assign accept     = hsel & hready & htrans[1];
    assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign take       = accept & can_accept;
    // A reset on the final data-phase edge drops the write.
    assign commit     = (state == S_DATA) & lat_write & ~hreset;
    assign fsm_state  = state;

    // BASE_ADDR is aligned to the array size, so the range check only has to
    // compare the address bits above the array.
    always_comb begin
        misalign = 1'b0;
        for (int i = 0; i < OFF_W; i++) begin
            if ((3'(i) < hsize) && haddr[i]) misalign = 1'b1;
        end
        addr_err = (haddr[ADDRWIDTH-1:HI_LSB] != BASE_ADDR[ADDRWIDTH-1:HI_LSB])
                 || (hsize > SIZE_MAX) || misalign;
    end

    // A read accepted on the edge where a write to the same word commits
    // returns the strobed lanes of the incoming data.
    always_comb begin
        rd_word = mem[idx];
        if (commit && (lat_idx == idx)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lat_strb[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE, S_DATA, S_ERR2: state_nxt = S_IDLE;
            S_WAIT: begin
                if (wcnt == 4'd0) state_nxt = S_DATA;
                else              wcnt_nxt  = wcnt - 4'd1;
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
        if (take) begin
            if (addr_err) begin
                state_nxt = S_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_nxt = S_DATA;
            end else begin
                state_nxt = S_WAIT;
                wcnt_nxt  = WAIT_LOAD;
            end
        end
        hreadyout = !((state == S_WAIT) || (state == S_ERR1));
        hresp     = (state == S_ERR1) || (state == S_ERR2);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            hrdata    <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_strb  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (take) begin
                lat_idx   <= idx;
                lat_write <= hwrite & ~addr_err;
                lat_strb  <= hwstrb;
                if (!hwrite && !addr_err) hrdata <= rd_word;
            end
        end
    end

    // The memory contents are not reset.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lat_strb[b]) mem[lat_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

endmodule
